rc4_decrypt_ctrl: RTL

- Top-level sequencer for the RC4 decrypt path.
- Starts key-scheduling in the RC4 state-array generator, then requests one keystream byte per ciphertext byte.
- XORs each keystream byte with the incoming ciphertext and emits plaintext over a valid/ready stream.
- Sits between the host byte stream and the generator FSM. Holds one prefetched keystream byte so generator latency overlaps ciphertext arrival.

---
 rtl/rc4_decrypt_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rc4_decrypt_ctrl.sv
// RC4 decrypt sequencer: runs the generator's key schedule, fetches one keystream byte per
// ciphertext byte and emits plaintext. Optional keystream discard is enabled with RC4_DROP_EN.
module rc4_decrypt_ctrl #(
    parameter int LEN_W  = 16,
    parameter int DROP_N = 256
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] msg_len_i,
    input  logic             cipher_valid_i,
    input  logic [7:0]       cipher_data_i,
    output logic             cipher_ready_o,
    output logic             plain_valid_o,
    output logic [7:0]       plain_data_o,
    input  logic             plain_ready_i,
    output logic             gen_state_arr_o,
    input  logic             sarr_generated_i,
    output logic             gen_val_o,
    input  logic             val_ready_i,
    input  logic [7:0]       keystream_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [LEN_W-1:0] bytes_done_o,
    output logic [3:0]       dbg_state
);

    // Streams: a byte moves on a rising edge where valid and ready are both high; valid never
    // drops and data never changes until that happens.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_KSA_GO    = 4'd1,
        S_KSA_WAIT  = 4'd2,
        S_KS_REQ    = 4'd3,
        S_KS_WAIT   = 4'd4,
        S_CT_WAIT   = 4'd5,
        S_DRAIN     = 4'd6,
        S_FIN       = 4'd7
`ifdef RC4_DROP_EN
        , S_DROP_REQ  = 4'd8,
        S_DROP_WAIT = 4'd9
`endif
    } state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] rem_cnt, rem_n, bd_n;
    logic [7:0]       ks_reg, ks_reg_n, pd_n;
    logic             ks_full, ks_full_n, pv_n;
    logic             wait_first, sarr_seen;
    logic             ready_n, gsa_n, gv_n, done_n, busy_n;
    logic             ct_xfer, pt_xfer, ks_hit;

    assign ct_xfer   = cipher_valid_i & cipher_ready_o;
    assign pt_xfer   = plain_valid_o & plain_ready_i;
    // val_ready_i may still show the previous byte during the cycle right after a request.
    assign ks_hit    = ~wait_first & val_ready_i;
    assign dbg_state = state;

`ifdef RC4_DROP_EN
    localparam int DROP_W = $clog2(DROP_N + 1);
    logic [DROP_W-1:0] drop_cnt;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i)                     drop_cnt <= '0;
        else if (state == S_KSA_WAIT)  drop_cnt <= '0;
        else if (state == S_DROP_REQ)  drop_cnt <= drop_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:     if (start_i) state_n = (msg_len_i == '0) ? S_FIN : S_KSA_GO;
            S_KSA_GO:   state_n = S_KSA_WAIT;
`ifdef RC4_DROP_EN
            S_KSA_WAIT: if (sarr_generated_i || sarr_seen) state_n = S_DROP_REQ;
            S_DROP_REQ: state_n = S_DROP_WAIT;
            S_DROP_WAIT: if (ks_hit) state_n = (drop_cnt == DROP_W'(DROP_N)) ? S_KS_REQ : S_DROP_REQ;
`else
            S_KSA_WAIT: if (sarr_generated_i || sarr_seen) state_n = S_KS_REQ;
`endif
            S_KS_REQ:   state_n = S_KS_WAIT;
            S_KS_WAIT:  if (ks_hit) state_n = S_CT_WAIT;
            S_CT_WAIT:  if (ct_xfer) state_n = (rem_cnt == LEN_W'(1)) ? S_DRAIN : S_KS_REQ;
            S_DRAIN:    if (pt_xfer) state_n = S_FIN;
            S_FIN:      state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    // Next values of every registered output, decoded from the next state so pulses line up
    // with the state that owns them.
    always_comb begin
        rem_n    = rem_cnt;
        ks_reg_n = ks_reg;
        ks_full_n = ks_full;
        pv_n     = plain_valid_o;
        pd_n     = plain_data_o;
        bd_n     = bytes_done_o;
        if (pt_xfer) begin
            pv_n = 1'b0;
            if (bytes_done_o != '1) bd_n = bytes_done_o + 1'b1;
        end
        if (state == S_IDLE && start_i) begin
            rem_n = msg_len_i;
            bd_n  = '0;
        end
        if (state == S_KS_WAIT && ks_hit) begin
            ks_reg_n  = keystream_i;
            ks_full_n = 1'b1;
        end
        if (state == S_CT_WAIT && ct_xfer) begin
            pd_n      = cipher_data_i ^ ks_reg;
            pv_n      = 1'b1;
            ks_full_n = 1'b0;
            rem_n     = rem_cnt - 1'b1;
        end
        gsa_n   = (state_n == S_KSA_GO);
`ifdef RC4_DROP_EN
        gv_n    = (state_n == S_KS_REQ) || (state_n == S_DROP_REQ);
`else
        gv_n    = (state_n == S_KS_REQ);
`endif
        done_n  = (state_n == S_FIN);
        busy_n  = (state_n != S_IDLE);
        ready_n = (state_n == S_CT_WAIT) && ks_full_n && !pv_n;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rem_cnt         <= '0;
            ks_reg          <= '0;
            ks_full         <= 1'b0;
            wait_first      <= 1'b0;
            sarr_seen       <= 1'b0;
            plain_valid_o   <= 1'b0;
            plain_data_o    <= '0;
            bytes_done_o    <= '0;
            cipher_ready_o  <= 1'b0;
            gen_state_arr_o <= 1'b0;
            gen_val_o       <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
        end else begin
            rem_cnt         <= rem_n;
            ks_reg          <= ks_reg_n;
            ks_full         <= ks_full_n;
`ifdef RC4_DROP_EN
            wait_first      <= (state == S_KS_REQ) || (state == S_DROP_REQ);
`else
            wait_first      <= (state == S_KS_REQ);
`endif
            // A completion pulse arriving before KSA_WAIT is held until it is consumed there.
            sarr_seen       <= (state_n == S_KSA_WAIT) && (sarr_seen || sarr_generated_i);
            plain_valid_o   <= pv_n;
            plain_data_o    <= pd_n;
            bytes_done_o    <= bd_n;
            cipher_ready_o  <= ready_n;
            gen_state_arr_o <= gsa_n;
            gen_val_o       <= gv_n;
            busy_o          <= busy_n;
            done_o          <= done_n;
        end
    end

endmodule
